sim_mmio_console: RTL
=====================

# sim_mmio_console

Parametrised memory-mapped simulation I/O peripheral for the PUC_RS5 testbench. It decodes CPU data-bus accesses in the testbench window and buffers console bytes from up to four channels in a shared FIFO. A valid/ready drain port feeds the printer. It also provides a 64-bit cycle timer with a coherent high-word read, a status register with a sticky overflow flag, and an end-of-simulation request carrying an exit code.

## Interface
- `NUM_CHANNELS`, default 2: number of console channels, 1..4.
- `FIFO_DEPTH`, default 16: number of FIFO entries; a power of two, ≥ 2.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en_i` in 1: access strobe; the address is already decoded to this window.
- `addr_i` in 16: byte offset inside the window; bits [1:0] are ignored.
- `we_i` in 4: byte write enables; nonzero = write, zero = read.
- `data_i` in 32: write data.
- `data_o` out 32: read data, registered.
- `out_valid_o` out 1: drain entry available.
- `out_ready_i` in 1: consumer accepts the entry.
- `out_data_o` out 8: byte at the FIFO head.
- `out_chan_o` out 2: channel of the FIFO head.
- `end_o` out 1: end-of-simulation request, sticky.
- `exit_code_o` out 8: exit code latched by the END write.

## Operation
- Register map (offset):
  - 0x0000 END (W): sets `end_o`; `exit_code_o` ← `data_i[7:0]`. A second END write updates the exit code.
  - 0x1000 + 4·c CHAR[c] (W), for c < `NUM_CHANNELS`: pushes {c, `data_i[7:0]`}. 0x4000 is an alias of CHAR[0].
  - 0x6000 TIMER_LO (R): returns `cycles[31:0]` and, in the same edge, latches `cycles[63:32]` into `hi_shadow`.
  - 0x6004 TIMER_HI (R): returns `hi_shadow`.
  - 0x7000 STATUS (R): [15:0] FIFO count; [16] overflow; [17] `end_o`. STATUS (W) with `data_i[16]`=1 clears overflow.
- Unmapped offsets, and CHAR[c] with c ≥ `NUM_CHANNELS`:
  - writes are ignored;
  - reads return 0.
- Reads of write-only registers return 0.
- FIFO behaviour:
  - push when `en_i` & `we_i`≠0 & CHAR address;
  - pop when `out_valid_o` & `out_ready_i`;
  - FIFO head drives `out_data_o`/`out_chan_o`; both are 0 when the FIFO is empty.
- Push while full:
  - with no pop in the same cycle, the byte is dropped and overflow is set;
  - with a pop in the same cycle, the push is accepted and the count is unchanged.
- Push and pop on a non-full, non-empty FIFO: count unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- `cycles`: 64-bit counter, incremented every cycle while `reset`=0, wraps 2^64−1 → 0.
- Overflow set and clear in the same cycle: set wins.
- After `end_o` the FIFO keeps draining, and pushes are still accepted.

## Timing
- Reset values, all taking effect on the edge where `reset`=1:
  - `data_o`, `cycles`, `hi_shadow`, FIFO pointers, count, overflow, `end_o`, `exit_code_o` = 0;
  - `out_valid_o` = 0.
- A reset in mid-operation discards all FIFO contents.
- Read latency 1: `data_o` is valid in the cycle after the `en_i` read cycle. `data_o` = 0 in any cycle not following a mapped read.
- TIMER_LO read at edge N returns the `cycles` value held before edge N. `hi_shadow` is taken from that same value, so the LO/HI pair is coherent.
- Push visible: `out_valid_o` rises one cycle after the push edge, i.e. the first-word fall-through latency is 1.
- Pop: the head advances on the handshake edge.
- `end_o` and `exit_code_o` update one cycle after the END write.
- STATUS read returns the count as it stood before the read edge.

## Configuration
- `SIM_MMIO_LINE_FLUSH_EN` defined — line buffering:
  - a counter tracks the 0x0A bytes held in the FIFO;
  - `out_valid_o` = ¬empty & (newline count > 0 | full | `end_o`);
  - the newline count is incremented on a push of 0x0A, decremented on a pop of 0x0A, unchanged when both happen in the same cycle.
- Undefined: `out_valid_o` = ¬empty, and no newline counter exists.

## Test plan
- Writes to CHAR[0] 'H', CHAR[1] 'i', 0x4000 '!' with `out_ready_i`=1 → drain sequence ('H',0), ('i',1), ('!',0); STATUS reads 0.
- `out_ready_i`=0, 17 pushes with `FIFO_DEPTH`=16 → STATUS = 0x0001_0010 and the 17th byte is absent. Then write STATUS 0x0001_0000 → overflow clears.
- Hold `cycles` at 0x0000_0000_FFFF_FFFF, read TIMER_LO then TIMER_HI across the carry → returns 0xFFFF_FFFF then 0x0000_0000, not 0x1.
- Full FIFO, push and pop in the same cycle → push accepted, count stays 16, overflow stays 0.
- Write END 0x2A → `end_o`=1, `exit_code_o`=0x2A on the next cycle. Assert `reset` with 5 bytes queued → `out_valid_o`=0, count=0, `end_o`=0 after the edge.
- With `SIM_MMIO_LINE_FLUSH_EN` defined: push "ab" → `out_valid_o` stays 0. Push 0x0A → `out_valid_o`=1 and 'a','b',0x0A drain, then `out_valid_o`=0.

Source files
------------

// File: rtl/sim_mmio_console.sv
// Simulation MMIO peripheral: console FIFO, 64-bit cycle timer, status and end-of-sim request.
// Optional line buffering of the drain port is enabled by defining SIM_MMIO_LINE_FLUSH_EN.
module sim_mmio_console #(
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [15:0] addr_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  out_data_o,
  output logic [1:0]  out_chan_o,
  output logic        end_o,
  output logic [7:0]  exit_code_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  // Word offsets (byte offset >> 2) of the register map.
  localparam logic [13:0] W_END        = 14'h0000;
  localparam logic [13:0] W_CHAR0      = 14'h0400;
  localparam logic [13:0] W_CHAR_ALIAS = 14'h1000;
  localparam logic [13:0] W_TIMER_LO   = 14'h1800;
  localparam logic [13:0] W_TIMER_HI   = 14'h1801;
  localparam logic [13:0] W_STATUS     = 14'h1C00;

  logic [13:0]   word;
  logic          wr_acc;
  logic          rd_acc;
  logic          char_hit;
  logic [1:0]    char_chan;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic          ovf_clr;
  logic          overflow;
  logic [63:0]   cycles;
  logic [31:0]   hi_shadow;
  logic [31:0]   status_word;
  logic          unused_bits;

  assign word   = addr_i[15:2];
  assign wr_acc = en_i && (we_i != 4'd0);
  assign rd_acc = en_i && (we_i == 4'd0);

  always_comb begin
    char_hit  = 1'b0;
    char_chan = 2'd0;
    if (word == W_CHAR_ALIAS) char_hit = 1'b1;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (word == W_CHAR0 + 14'(c)) begin
        char_hit  = 1'b1;
        char_chan = 2'(c);
      end
    end
  end

  // Drain handshake: an entry transfers on a rising clk edge where out_valid_o
  // and out_ready_i are both high; data/chan are stable while valid is held.
  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = out_valid_o && out_ready_i;
  assign push_req = wr_acc && char_hit;
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = wr_acc && (word == W_STATUS) && data_i[16];

  assign out_data_o = empty ? 8'd0 : mem[rd_ptr][7:0];
  assign out_chan_o = empty ? 2'd0 : mem[rd_ptr][9:8];

  assign status_word = {14'd0, end_o, overflow, 16'(count)};
  assign unused_bits = ^{addr_i[1:0], data_i[31:17], data_i[15:8]};

`ifdef SIM_MMIO_LINE_FLUSH_EN
  logic [CW-1:0] nl_count;
  logic          push_nl;
  logic          pop_nl;

  assign push_nl = push && (data_i[7:0] == 8'h0A);
  assign pop_nl  = pop && (mem[rd_ptr][7:0] == 8'h0A);

  always_ff @(posedge clk) begin
    if (reset) begin
      nl_count <= '0;
    end else if (push_nl && !pop_nl) begin
      nl_count <= nl_count + CW'(1);
    end else if (pop_nl && !push_nl) begin
      nl_count <= nl_count - CW'(1);
    end
  end

  // Hold bytes back until a full line, a full FIFO or end of simulation.
  assign out_valid_o = !empty && ((nl_count != '0) || full || end_o);
`else
  assign out_valid_o = !empty;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {char_chan, data_i[7:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_o      <= '0;
      cycles      <= '0;
      hi_shadow   <= '0;
      overflow    <= 1'b0;
      end_o       <= 1'b0;
      exit_code_o <= '0;
    end else begin
      cycles <= cycles + 64'd1;
      data_o <= '0;
      if (rd_acc) begin
        case (word)
          W_TIMER_LO: begin
            data_o    <= cycles[31:0];
            hi_shadow <= cycles[63:32];
          end
          W_TIMER_HI: data_o <= hi_shadow;
          W_STATUS:   data_o <= status_word;
          default:    data_o <= '0;
        endcase
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      if (wr_acc && (word == W_END)) begin
        end_o       <= 1'b1;
        exit_code_o <= data_i[7:0];
      end
    end
  end

endmodule
